// File: rtl/mips_div_pkg.sv
// Shared types and constants for the multi-cycle divide unit.
// Early-out behaviour is enabled with MIPS_DIV_EARLY_OUT_EN.
package mips_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration: shift, trial subtract, select.
// Purely combinational; the top sequences it once per clock.
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             take;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        // One extra bit so a borrow is never confused with a large remainder
        diff    = shifted - {2'b00, dvs};
        take    = ~diff[WIDTH+1];
        rem_out = take ? diff[WIDTH:0] : shifted[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], take};
    end

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle signed/unsigned divider producing HI (remainder) and LO (quotient).
// Define MIPS_DIV_EARLY_OUT_EN to skip iterations for zero or oversized divisors.
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e state, state_nx;

    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   pr, pr_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic [WIDTH-1:0] dmag, raw;
    logic             qsign, rsign, dz;

    logic             a_neg, b_neg, early;
    logic [WIDTH-1:0] amag, bmag;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign amag  = a_neg ? -dividend : dividend;
    assign bmag  = b_neg ? -divisor : divisor;

`ifdef MIPS_DIV_EARLY_OUT_EN
    assign early = (divisor == '0) || (amag < bmag);
`else
    assign early = 1'b0;
`endif

    mips_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (pr),
        .quo_in (q),
        .dvs    (dmag),
        .rem_out(pr_nx),
        .quo_out(q_nx)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = early ? FIX : RUN;
            RUN:  if (count == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            pr          <= '0;
            q           <= '0;
            dmag        <= '0;
            raw         <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        qsign <= a_neg ^ b_neg;
                        rsign <= a_neg;
                        raw   <= dividend;
                        dz    <= (divisor == '0);
                        dmag  <= bmag;
                        // Early out leaves the whole dividend as remainder
                        pr    <= early ? {1'b0, amag} : '0;
                        q     <= early ? '0 : amag;
                    end
                end
                RUN: begin
                    pr    <= pr_nx;
                    q     <= q_nx;
                    count <= count + 1'b1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    quotient    <= dz ? WIDTH'(DIV_ZERO_QUO)
                                      : (qsign ? -q : q);
                    remainder   <= dz ? raw
                                      : WIDTH'(rsign ? -pr : pr);
                end
                default: ;
            endcase
        end
    end

endmodule
